exec_sequencer: RTL

//  Run-control sequencer for the single-cycle RISC-V core. Gates PC advance and architectural

---
 rtl/exec_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// exec_sequencer
//   Run-control sequencer for the single-cycle RISC-V core. It decides, cycle by
//   cycle, whether the PC may advance and whether the register file and data
//   memory may commit. With these enables the core can sit idle, run freely,
//   execute one instruction at a time, pause on request, and stop for good on
//   EBREAK, an illegal encoding or watchdog expiry.
//
// Parameters
//   CNT_W          width of the cycle and retired-instruction counters
//   MAX_CYCLES     watchdog limit on cycles spent in RUN/STEP
//
// Ports
//   clock          system clock, all state updates on posedge
//   reset          synchronous, active-low reset
//   start          enter RUN from IDLE or HALT
//   step           execute exactly one instruction from IDLE or HALT
//   halt_req       pause after the current instruction commits (RUN only)
//   instruction    currently fetched instruction word
//   pc_enable      PC may load its next address this cycle
//   commit_en      qualifies regWrite / memWrite this cycle
//   running        state is RUN or STEP
//   halted         state is HALT
//   done           state is DONE (sticky until reset)
//   halt_cause     00 none, 01 EBREAK, 10 watchdog, 11 illegal
//   cycle_count    cycles spent in RUN/STEP, saturating at MAX_CYCLES
//   retired_count  instructions committed, wraps modulo 2^CNT_W

module exec_sequencer #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 200
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic [31:0]      instruction,
  output logic             pc_enable,
  output logic             commit_en,
  output logic             running,
  output logic             halted,
  output logic             done,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_HALT,
    S_DONE
  } state_t;

  localparam logic [31:0]      EBREAK_WORD = 32'h0010_0073;
  localparam logic [CNT_W-1:0] WD_LIMIT    = CNT_W'(MAX_CYCLES);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_EBREAK   = 2'b01;
  localparam logic [1:0] CAUSE_WATCHDOG = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic is_ebreak;
  logic is_illegal;
  logic wd_hit;
  logic in_exec;
  logic exec;

  // Decode the stop conditions. An all-zero or all-ones word is what an
  // unprogrammed or out-of-range memory returns, so both count as illegal.
  // The watchdog fires on the cycle whose counter has reached the limit, so
  // exactly MAX_CYCLES instructions can execute before the forced stop.
  always_comb begin
    is_ebreak  = (instruction == EBREAK_WORD);
    is_illegal = (instruction == 32'h0000_0000) || (instruction == 32'hFFFF_FFFF);
    wd_hit     = (cycle_q == WD_LIMIT);
    in_exec    = (state_q == S_RUN) || (state_q == S_STEP);
    exec       = in_exec && !is_ebreak && !is_illegal && !wd_hit;
  end

  // Next-state, stop cause and counters. A stopping instruction (EBREAK,
  // illegal, watchdog) never commits; halt_req in RUN still lets the current
  // instruction commit and only redirects the following cycle to HALT.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    cycle_d   = cycle_q;
    retired_d = retired_q;

    if (in_exec && (cycle_q < WD_LIMIT)) begin
      cycle_d = cycle_q + 1'b1;
    end

    if (exec) begin
      retired_d = retired_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_RUN;
        end else if (step) begin
          state_d = S_STEP;
        end
      end
      S_RUN, S_STEP: begin
        if (is_ebreak) begin
          state_d = S_DONE;
          cause_d = CAUSE_EBREAK;
        end else if (is_illegal) begin
          state_d = S_DONE;
          cause_d = CAUSE_ILLEGAL;
        end else if (wd_hit) begin
          state_d = S_DONE;
          cause_d = CAUSE_WATCHDOG;
        end else if (state_q == S_STEP) begin
          state_d = S_HALT;
        end else if (halt_req) begin
          state_d = S_HALT;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset is sampled on the clock edge and beats every input.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cause_q   <= CAUSE_NONE;
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
    end
  end

  // Enables are combinational so the core commits with no added latency.
  always_comb begin
    pc_enable     = exec;
    commit_en     = exec;
    running       = in_exec;
    halted        = (state_q == S_HALT);
    done          = (state_q == S_DONE);
    halt_cause    = cause_q;
    cycle_count   = cycle_q;
    retired_count = retired_q;
  end

endmodule
